// File: rtl/ub_dma_controller.sv
// ub_dma_controller
// Command-driven byte-stream DMA engine for the unified buffer FIFO port.
// A load command writes a word range from the inbound byte stream into the buffer.
// An unload command reads a word range out onto the outbound byte stream.
// Buffer strobes are registered. Only the FIFO path of the buffer is driven.
// Optional macro UB_DMA_HIGH_FIRST_EN moves the high byte of each word first.
// When the macro is undefined (default), the low byte goes first.
module ub_dma_controller #(
  parameter int ADDRESS_SIZE    = 10,
  parameter int FIFO_DATA_WIDTH = 8,   // half of the buffer word width
  parameter int LEN_WIDTH       = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_dir,
  input  logic [ADDRESS_SIZE-1:0]    cmd_addr,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic [FIFO_DATA_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FIFO_DATA_WIDTH-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       ub_we,
  output logic                       ub_re,
  output logic                       ub_fifo_en,
  output logic                       ub_compute_en,
  output logic                       ub_store_en,
  output logic                       ub_section,
  output logic [ADDRESS_SIZE-1:0]    ub_address,
  output logic [FIFO_DATA_WIDTH-1:0] ub_fifo_in,
  input  logic [FIFO_DATA_WIDTH-1:0] ub_fifo_out,
  input  logic                       ub_done,
  output logic                       busy,
  output logic                       cmd_done
);

  // The byte counter needs one bit more than the word count.
  localparam int KW = LEN_WIDTH + 1;

`ifdef UB_DMA_HIGH_FIRST_EN
  localparam logic HIGH_FIRST = 1'b1;
`else
  localparam logic HIGH_FIRST = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_FINISH
  } state_e;

  state_e                     state_q, state_d;
  logic [KW-1:0]              k_q, k_d;
  logic [ADDRESS_SIZE-1:0]    addr_q, addr_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic                       dir_q, dir_d;
  logic [FIFO_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                       we_q, we_d, re_q, re_d, fifo_en_q, fifo_en_d;
  logic                       section_q, section_d;
  logic [ADDRESS_SIZE-1:0]    address_q, address_d;
  logic [FIFO_DATA_WIDTH-1:0] fifo_in_q, fifo_in_d;
  logic                       cmd_done_q, cmd_done_d;

  logic          cmd_fire, in_fire, out_fire, last_byte, rd_wait_done;
  logic          wr_access, rd_access;
  logic [KW-1:0] acc_k;

  // Moore stream/handshake outputs decoded from the current state
  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign in_ready     = (state_q == S_LOAD) & ~dir_q;
  assign out_valid    = (state_q == S_RD_OUT) & dir_q;
  assign cmd_fire     = cmd_valid & cmd_ready;
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = out_valid & out_ready;
  assign rd_wait_done = (state_q == S_RD_WAIT) & ub_done;
  assign last_byte    = ((k_q + KW'(1)) == {len_q, 1'b0});

  assign out_data      = out_data_q;
  assign ub_we         = we_q;
  assign ub_re         = re_q;
  assign ub_fifo_en    = fifo_en_q;
  assign ub_section    = section_q;
  assign ub_address    = address_q;
  assign ub_fifo_in    = fifo_in_q;
  assign ub_compute_en = 1'b0;
  assign ub_store_en   = 1'b0;
  assign cmd_done      = cmd_done_q;

  // State register; reset aborts any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) state_d = S_FINISH;
          else if (cmd_dir)  state_d = S_RD_REQ;
          else               state_d = S_LOAD;
        end
      end
      S_LOAD:    if (in_fire && last_byte) state_d = S_FINISH;
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: if (ub_done) state_d = S_RD_OUT;
      S_RD_OUT:  if (out_fire) state_d = last_byte ? S_FINISH : S_RD_REQ;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: command latch, byte counter and next buffer strobe values
  always_comb begin
    k_d        = k_q;
    addr_d     = addr_q;
    len_d      = len_q;
    dir_d      = dir_q;
    out_data_d = out_data_q;
    if (cmd_fire) begin
      k_d    = '0;
      addr_d = cmd_addr;
      len_d  = cmd_len;
      dir_d  = cmd_dir;
    end else if (in_fire || out_fire) begin
      k_d = k_q + KW'(1);
    end
    if (rd_wait_done) out_data_d = ub_fifo_out;

    // A write carries the byte just handshaken; a read request is issued for
    // the byte the counter points at once the request state is entered.
    wr_access = in_fire;
    rd_access = (state_d == S_RD_REQ);
    acc_k     = wr_access ? k_q : k_d;

    we_d      = wr_access;
    re_d      = rd_access;
    fifo_en_d = wr_access | rd_access;
    section_d = 1'b0;
    address_d = '0;
    fifo_in_d = '0;
    if (wr_access || rd_access) begin
      section_d = acc_k[0] ^ HIGH_FIRST;
      address_d = addr_d + ADDRESS_SIZE'(acc_k[KW-1:1]);  // wraps modulo buffer size
    end
    if (wr_access) fifo_in_d = in_data;
    cmd_done_d = (state_q == S_FINISH);
  end

  // Datapath registers and registered buffer strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q        <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      dir_q      <= 1'b0;
      out_data_q <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      fifo_en_q  <= 1'b0;
      section_q  <= 1'b0;
      address_q  <= '0;
      fifo_in_q  <= '0;
      cmd_done_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      out_data_q <= out_data_d;
      we_q       <= we_d;
      re_q       <= re_d;
      fifo_en_q  <= fifo_en_d;
      section_q  <= section_d;
      address_q  <= address_d;
      fifo_in_q  <= fifo_in_d;
      cmd_done_q <= cmd_done_d;
    end
  end

endmodule

// File: tb/tb_ub_dma_controller.sv
// Testbench for ub_dma_controller: directed and randomized load/unload commands
// against a word-level buffer model plus a reference image of buffer contents.
module tb_ub_dma_controller;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 11;
`ifdef UB_DMA_HIGH_FIRST_EN
  localparam bit HF = 1'b1;
`else
  localparam bit HF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_dir = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, out_ready = 1'b0, done_inject = 1'b0;
  logic          cmd_ready, in_ready, out_valid, busy, cmd_done;
  logic [DW-1:0] out_data, ub_fifo_in, ub_fifo_out;
  logic          ub_we, ub_re, ub_fifo_en, ub_compute_en, ub_store_en, ub_section;
  logic [AW-1:0] ub_address;
  logic          ub_done, resp_done;

  int total = 0;
  int bad = 0;
  logic [15:0] buf_mem [0:1023];   // buffer model, written only by the DUT
  logic [15:0] ref_mem [0:1023];   // expected buffer image
  logic [7:0]  load_bytes[$];
  logic [7:0]  got_bytes[$];

  assign ub_done = resp_done | done_inject;
  always #5 clk = ~clk;

  ub_dma_controller dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ub_we(ub_we), .ub_re(ub_re), .ub_fifo_en(ub_fifo_en),
    .ub_compute_en(ub_compute_en), .ub_store_en(ub_store_en),
    .ub_section(ub_section), .ub_address(ub_address),
    .ub_fifo_in(ub_fifo_in), .ub_fifo_out(ub_fifo_out), .ub_done(ub_done),
    .busy(busy), .cmd_done(cmd_done)
  );

  // Unified buffer FIFO-port model: read data and done one cycle after ub_re
  always @(posedge clk) begin
    resp_done <= ub_re & ub_fifo_en;
    if (ub_re) ub_fifo_out <= ub_section ? buf_mem[ub_address][15:8] : buf_mem[ub_address][7:0];
    if (ub_we & ub_fifo_en) begin
      if (ub_section) buf_mem[ub_address][15:8] <= ub_fifo_in;
      else            buf_mem[ub_address][7:0]  <= ub_fifo_in;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] byte_addr(input logic [AW-1:0] a, input int k);
    return AW'(int'(a) + k / 2);
  endfunction

  function automatic logic byte_sec(input int k);
    return ((k % 2) == 1) ^ HF;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [AW-1:0] a, input int k);
    logic [15:0] w;
    w = ref_mem[byte_addr(a, k)];
    return byte_sec(k) ? w[15:8] : w[7:0];
  endfunction

  // Offer a command at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic dir, input logic [AW-1:0] a, input int n);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = a; cmd_len = LW'(n);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Called in the FINISH cycle: done pulses in the next cycle only
  task automatic finish_seq();
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_no_done_yet", 32'(cmd_done), 32'd0);
    chk("fin_re", 32'(ub_re), 32'd0);
    chk("fin_streams", 32'({in_ready, out_valid}), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(cmd_done), 32'd1);
    chk("done_idle", 32'({busy, cmd_ready}), 32'b01);
    chk("done_quiet", 32'({ub_we, ub_re, ub_fifo_en}), 32'd0);
    @(negedge clk);
    chk("done_once", 32'(cmd_done), 32'd0);
  endtask

  task automatic run_load(input logic [AW-1:0] a, input int nw, input int gap_pct);
    int nb = 2 * nw;
    int k = 0;
    int guard = 0;
    bit hs;
    logic [AW-1:0] pa;
    logic ps;
    logic [7:0] pd;
    issue(1'b0, a, nw);
    if (nb == 0) chk("ld0_we", 32'({ub_we, ub_re}), 32'd0);
    while (k < nb && guard < 5000) begin
      chk("ld_in_ready", 32'(in_ready), 32'd1);
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data = load_bytes[k];
      hs = in_valid;
      if (hs) begin
        pa = byte_addr(a, k); ps = byte_sec(k); pd = load_bytes[k];
        if (ps) ref_mem[pa][15:8] = pd; else ref_mem[pa][7:0] = pd;
        k++;
      end
      done_inject = ($urandom_range(3) == 0);
      @(negedge clk);
      guard++;
      if (hs) begin
        chk("ld_we", 32'({ub_we, ub_fifo_en}), 32'b11);
        chk("ld_addr", 32'(ub_address), 32'(pa));
        chk("ld_sec", 32'(ub_section), 32'(ps));
        chk("ld_data", 32'(ub_fifo_in), 32'(pd));
      end else begin
        chk("ld_we_gap", 32'(ub_we), 32'd0);
      end
      chk("ld_re", 32'(ub_re), 32'd0);
    end
    in_valid = 1'b0; done_inject = 1'b0;
    if (k < nb) chk("ld_timeout", 32'(k), 32'(nb));
    finish_seq();
  endtask

  task automatic run_unload(input logic [AW-1:0] a, input int nw, input int rdy_pct,
                            input int stall_byte, input int stall_len);
    int nb = 2 * nw;
    int k_req = 0, k_out = 0, since_re = 0, stall_cnt = 0, guard = 0, cyc = 0, last_re = -1;
    bit pending = 0, want_re, exp_ov, hs;
    got_bytes.delete();
    issue(1'b1, a, nw);
    want_re = (nb > 0);
    while (k_out < nb && guard < 5000) begin
      chk("ul_we", 32'(ub_we), 32'd0);
      chk("ul_re", 32'(ub_re), 32'(want_re));
      if (want_re) begin
        chk("ul_re_addr", 32'(ub_address), 32'(byte_addr(a, k_req)));
        chk("ul_re_sec", 32'({ub_section, ub_fifo_en}), 32'({byte_sec(k_req), 1'b1}));
        if (last_re >= 0) chk("ul_re_spacing", 32'(cyc - last_re >= 3), 32'd1);
        last_re = cyc; pending = 1; since_re = 0; k_req++;
      end else if (pending) begin
        since_re++;
      end
      exp_ov = pending && since_re >= 2;
      chk("ul_out_valid", 32'(out_valid), 32'(exp_ov));
      hs = 0;
      if (exp_ov) begin
        chk("ul_out_data", 32'(out_data), 32'(ref_byte(a, k_out)));
        if (k_out == stall_byte && stall_cnt < stall_len) begin
          out_ready = 1'b0; stall_cnt++;
        end else begin
          out_ready = ($urandom_range(99) < rdy_pct);
        end
        hs = out_ready;
        if (hs) begin
          got_bytes.push_back(out_data); k_out++; pending = 0;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
      end
      want_re = hs && (k_out < nb);
      done_inject = ($urandom_range(3) == 0);
      @(negedge clk);
      cyc++; guard++;
    end
    out_ready = 1'b0; done_inject = 1'b0;
    if (k_out < nb) chk("ul_timeout", 32'(k_out), 32'(nb));
    finish_seq();
  endtask

  initial begin
    logic [7:0] exp_dir [4];
    int off, nw;

    // Reset and idle quiescence
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_strobes", 32'({ub_we, ub_re, ub_fifo_en, busy, cmd_done}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", 32'({ub_we, ub_re, ub_fifo_en, ub_compute_en, ub_store_en,
                            ub_section, in_ready, out_valid, busy, cmd_done}), 32'd0);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
    end
    chk("idle_bus", 32'({ub_address, ub_fifo_in, out_data}), 32'd0);

    // Directed load, one byte per cycle
    load_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_load(10'h010, 2, 0);

    // Fill a window that wraps past the top of the buffer
    load_bytes.delete();
    for (int i = 0; i < 64; i++) load_bytes.push_back(8'($urandom_range(255)));
    run_load(10'h3F0, 32, 30);

    // Words 0x3FF = 0x1234 and 0x000 = 0x5678, then read them back
    if (HF) begin
      exp_dir[0] = 8'h12; exp_dir[1] = 8'h34; exp_dir[2] = 8'h56; exp_dir[3] = 8'h78;
    end else begin
      exp_dir[0] = 8'h34; exp_dir[1] = 8'h12; exp_dir[2] = 8'h78; exp_dir[3] = 8'h56;
    end
    load_bytes.delete();
    for (int i = 0; i < 4; i++) load_bytes.push_back(exp_dir[i]);
    run_load(10'h3FF, 2, 0);
    run_unload(10'h3FF, 2, 100, -1, 0);
    chk("dir_unload_count", 32'(got_bytes.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_bytes.size(); i++)
      chk("dir_unload_byte", 32'(got_bytes[i]), 32'(exp_dir[i]));

    // Back-pressure: out_ready low for 5 cycles on byte 1
    run_unload(10'h3F2, 2, 100, 1, 5);

    // Zero-length commands
    run_load(10'h055, 0, 0);
    run_unload(10'h066, 0, 100, -1, 0);

    // Reset in the middle of a load after three bytes
    issue(1'b0, 10'h200, 4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h60 + i);
      @(negedge clk);
    end
    chk("rst_mid_we_before", 32'(ub_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", 32'({ub_we, ub_re, ub_fifo_en, in_ready, busy}), 32'd0);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_done", 32'(cmd_done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle", 32'({cmd_ready, busy, cmd_done}), 32'b100);
    load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(10'h020, 2, 0);

    // Randomized commands inside the filled window (including wrap)
    for (int t = 0; t < 24; t++) begin
      off = $urandom_range(31);
      nw = $urandom_range((32 - off) > 6 ? 6 : (32 - off), 0);
      if ($urandom_range(1) == 0) begin
        load_bytes.delete();
        for (int i = 0; i < 2 * nw; i++) load_bytes.push_back(8'($urandom_range(255)));
        run_load(AW'(10'h3F0 + off), nw, $urandom_range(50));
      end else begin
        run_unload(AW'(10'h3F0 + off), nw, $urandom_range(100, 30), -1, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
